// File: rtl/fifo_stagger_control_pkg.sv
// Shared constants for the FIFO stagger loader.
// Lane defaults, burst mode codes and controller state encodings.
package fifo_stagger_control_pkg;

    localparam int DEF_FIFO_WIDTH = 16;
    localparam int DEF_DEPTH      = 16;

    localparam logic MODE_FLAT    = 1'b0;
    localparam logic MODE_STAGGER = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/fifo_stagger_control_lane_window.sv
// Per-lane push window: enabled while the beat index lies in
// [lo, lo+DEPTH), where lo is the lane index in stagger mode, else 0.
module fifo_stagger_control_lane_window #(
    parameter int LANE        = 0,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = 6
) (
    input  logic                   valid_i,
    input  logic                   mode_i,
    input  logic [COUNT_WIDTH-1:0] count_i,
    output logic                   en_o
);

    localparam logic [COUNT_WIDTH-1:0] LANE_C  = COUNT_WIDTH'(LANE);
    localparam logic [COUNT_WIDTH-1:0] DEPTH_C = COUNT_WIDTH'(DEPTH);

    logic [COUNT_WIDTH-1:0] lo;
    logic [COUNT_WIDTH-1:0] hi;

    assign lo   = mode_i ? LANE_C : '0;
    assign hi   = lo + DEPTH_C;
    assign en_o = valid_i & (count_i >= lo) & (count_i < hi);

endmodule

// File: rtl/fifo_stagger_control.sv
// Sequences one flat or diagonal load burst into the FIFO bank,
// with stall support, weight-write strobe and a completion pulse.
module fifo_stagger_control
    import fifo_stagger_control_pkg::*;
#(
    parameter int FIFO_WIDTH    = DEF_FIFO_WIDTH,
    parameter int DEPTH         = DEF_DEPTH,
    parameter int WEIGHT_CYCLES = FIFO_WIDTH - 1,
    localparam int COUNT_WIDTH  = $clog2(DEPTH + FIFO_WIDTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active,
    input  logic                   stagger_load,
    input  logic                   hold,
    output logic [FIFO_WIDTH-1:0]  fifo_en,
    output logic                   weight_write,
    output logic                   done,
    output logic                   done_pulse,
    output logic [COUNT_WIDTH-1:0] beat
);

    localparam logic [COUNT_WIDTH-1:0] T_FLAT =
        COUNT_WIDTH'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] T_STAG =
        COUNT_WIDTH'(DEPTH + FIFO_WIDTH - 2);
    localparam logic [COUNT_WIDTH-1:0] WC =
        COUNT_WIDTH'(WEIGHT_CYCLES);

    logic [0:0]             state_q, state_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   mode_q, mode_d;
    logic                   pulse_q, pulse_d;

    logic                   valid;
    logic                   at_term;
    logic [COUNT_WIDTH-1:0] term;

    assign term    = (mode_q == MODE_STAGGER) ? T_STAG : T_FLAT;
    assign valid   = (state_q == ST_RUN) & ~hold;
    assign at_term = valid & (count_q == term);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (active) begin
                    state_d = ST_RUN;
                    count_d = '0;
                    mode_d  = stagger_load;
                end
            end
            ST_RUN: begin
                // A held beat at the terminal count keeps the burst open.
                if (at_term) begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    pulse_d = 1'b1;
                end else if (valid) begin
                    count_d = count_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mode_q  <= MODE_FLAT;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            pulse_q <= pulse_d;
        end
    end

    for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_lane
        fifo_stagger_control_lane_window #(
            .LANE        (i),
            .DEPTH       (DEPTH),
            .COUNT_WIDTH (COUNT_WIDTH)
        ) u_win (
            .valid_i (valid),
            .mode_i  (mode_q),
            .count_i (count_q),
            .en_o    (fifo_en[i])
        );
    end

    assign weight_write = valid & (count_q < WC);
    assign done         = (state_q == ST_IDLE);
    assign done_pulse   = pulse_q;
    assign beat         = count_q;

endmodule
